// File: rtl/seg7_scan_display.sv
// Time-multiplexed hex driver for a DIGITS-wide common-segment 7-segment bank.
// The value is snapshotted once per scan frame, and each digit switch is preceded by one blank cycle.
module seg7_scan_display #(
   parameter int DIGITS          = 4,
   parameter int SCAN_DIV        = 50000,
   parameter bit SEG_ACTIVE_LOW  = 1'b1,
   parameter bit SEL_ACTIVE_HIGH = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] in,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                en,
   input  logic                lz_blank,
   output logic [6:0]          out,
   output logic                dp,
   output logic [DIGITS-1:0]   sel,
   output logic                frame
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0]     PLAST   = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     ILAST   = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
   localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_HIGH ? {DIGITS{1'b0}} : {DIGITS{1'b1}};

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0:    hex7 = 7'b1000000;
         4'h1:    hex7 = 7'b1111001;
         4'h2:    hex7 = 7'b0100100;
         4'h3:    hex7 = 7'b0110000;
         4'h4:    hex7 = 7'b0011001;
         4'h5:    hex7 = 7'b0010010;
         4'h6:    hex7 = 7'b0000010;
         4'h7:    hex7 = 7'b1111000;
         4'h8:    hex7 = 7'b0000000;
         4'h9:    hex7 = 7'b0010000;
         4'ha:    hex7 = 7'b0001000;
         4'hb:    hex7 = 7'b0000011;
         4'hc:    hex7 = 7'b1000110;
         4'hd:    hex7 = 7'b0100001;
         4'he:    hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   logic [PW-1:0]       pcnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow;
   logic [DIGITS-1:0]   dp_sh;
   logic                primed;
   logic                bl;
   logic                tick;
   logic                snap;

   assign tick = (pcnt == PLAST);
   // First edge out of reset loads the shadow so the display never shows stale zeros
   assign snap = !primed || (tick && (idx == ILAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt   <= '0;
         idx    <= '0;
         shadow <= '0;
         dp_sh  <= '0;
         primed <= 1'b0;
         bl     <= 1'b1;
         frame  <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         if (tick)
            idx <= (idx == ILAST) ? '0 : idx + 1'b1;
         if (snap) begin
            shadow <= in;
            dp_sh  <= dp_in;
         end
         primed <= 1'b1;
         bl     <= tick;
         frame  <= snap;
      end
   end

   logic [DIGITS-1:0] nz;
   logic [DIGITS-1:0] supp;
   logic [DIGITS-1:0] one;
   logic [3:0]        nib;
   logic [6:0]        raw;
   logic [6:0]        lit;

   // nz[i]: digit i or any digit above it is nonzero
   always_comb begin
      nz = '0;
      nz[DIGITS-1] = |shadow[4*DIGITS-1 -: 4];
      for (int j = DIGITS-2; j >= 0; j--)
         nz[j] = nz[j+1] | (|shadow[4*j +: 4]);
      supp = '0;
      for (int j = 1; j < DIGITS; j++)
         supp[j] = lz_blank && !nz[j];
   end

   always_comb begin
      one      = '0;
      one[idx] = 1'b1;
      nib      = shadow[{idx, 2'b00} +: 4];
      raw      = supp[idx] ? 7'h7f : hex7(nib);
      lit      = SEG_ACTIVE_LOW ? raw : ~raw;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= SEG_OFF;
         dp  <= DP_OFF;
         sel <= SEL_OFF;
      end else if (!en || bl) begin
         out <= SEG_OFF;
         dp  <= DP_OFF;
         sel <= SEL_OFF;
      end else begin
         out <= lit;
         dp  <= dp_sh[idx] ? ~DP_OFF : DP_OFF;
         sel <= SEL_ACTIVE_HIGH ? one : ~one;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display (DIGITS=4, SCAN_DIV=4): vector table, hand-written scan sequences,
// and random stimulus against a cycle-count arithmetic model of the scan schedule.
module tb_seg7_scan_display;
   localparam int D  = 4;
   localparam int S  = 4;
   localparam int FP = D * S;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_r;
   logic [3:0]  dp_r;
   logic        en_r;
   logic        lz_r;
   logic [6:0]  out;
   logic        dp;
   logic [3:0]  sel;
   logic        frame;

   int          checks = 0;
   int          errors = 0;
   int          k = 0;
   logic [15:0] m_sh;
   logic [3:0]  m_dp;
   logic [6:0]  segtab [16];

   typedef struct {
      logic [15:0] v;
      logic [3:0]  dpi;
      logic        lz;
      int          dig;
      logic [6:0]  eo;
      logic        ed;
   } vec_t;
   vec_t vecs[$];

   seg7_scan_display #(.DIGITS(D), .SCAN_DIV(S), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_HIGH(1'b1)) dut (
      .clk(clk), .rst(rst), .in(in_r), .dp_in(dp_r), .en(en_r), .lz_blank(lz_r),
      .out(out), .dp(dp), .sel(sel), .frame(frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (edge %0d)", name, act, exp, k);
      end
   endtask

   // Edge k after reset release: slot blank when (k-1)%S==0, digit ((k-1)/S)%D, snapshot at k==1 or k%FP==0
   task automatic step();
      logic [15:0] in_p;
      logic [3:0]  dp_p, es;
      logic        en_p, lz_p, ed;
      logic [6:0]  eo;
      int          d;
      in_p = in_r; dp_p = dp_r; en_p = en_r; lz_p = lz_r;
      @(posedge clk); #1;
      k++;
      if (!en_p || ((k-1) % S) == 0) begin
         es = 4'h0; eo = 7'h7f; ed = 1'b1;
      end else begin
         d  = ((k-1) / S) % D;
         es = 4'(1 << d);
         if (lz_p && d > 0 && (m_sh >> (4*d)) == 16'h0) eo = 7'h7f;
         else eo = segtab[m_sh[4*d +: 4]];
         ed = ~m_dp[d];
      end
      check("m_sel", 32'(sel), 32'(es));
      check("m_out", 32'(out), 32'(eo));
      check("m_dp", 32'(dp), 32'(ed));
      check("m_frame", 32'(frame), 32'(k == 1 || (k % FP) == 0));
      if (k == 1 || (k % FP) == 0) begin
         m_sh = in_p;
         m_dp = dp_p;
      end
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin step(); n++; end while (frame !== 1'b1 && n < 3*FP);
      check("wait_frame", 32'(frame), 32'd1);
   endtask

   task automatic wait_sel(input logic [3:0] t);
      int n = 0;
      while (sel !== t && n < 3*FP) begin step(); n++; end
      check("wait_sel", 32'(sel), 32'(t));
   endtask

   task automatic model_reset();
      k = 0; m_sh = 16'h0; m_dp = 4'h0;
   endtask

   initial begin
      logic [6:0] scan_exp [4];
      segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      scan_exp = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};
      vecs.push_back('{16'h0050, 4'h0, 1'b1, 3, 7'b1111111, 1'b1});
      vecs.push_back('{16'h0050, 4'h0, 1'b1, 2, 7'b1111111, 1'b1});
      vecs.push_back('{16'h0050, 4'h0, 1'b1, 1, 7'b0010010, 1'b1});
      vecs.push_back('{16'h0050, 4'h0, 1'b1, 0, 7'b1000000, 1'b1});
      vecs.push_back('{16'h0000, 4'h0, 1'b1, 1, 7'b1111111, 1'b1});
      vecs.push_back('{16'h0000, 4'h0, 1'b1, 0, 7'b1000000, 1'b1});
      vecs.push_back('{16'h0000, 4'h4, 1'b1, 2, 7'b1111111, 1'b0});
      vecs.push_back('{16'h0050, 4'h0, 1'b0, 3, 7'b1000000, 1'b1});
      vecs.push_back('{16'h0f00, 4'h0, 1'b1, 2, 7'b0001110, 1'b1});
      vecs.push_back('{16'h8000, 4'h0, 1'b1, 1, 7'b1000000, 1'b1});
      vecs.push_back('{16'h79e6, 4'h0, 1'b0, 0, 7'b0000010, 1'b1});
      vecs.push_back('{16'h79e6, 4'h0, 1'b0, 1, 7'b0000110, 1'b1});
      vecs.push_back('{16'h79e6, 4'h0, 1'b0, 2, 7'b0010000, 1'b1});
      vecs.push_back('{16'h79e6, 4'h0, 1'b0, 3, 7'b1111000, 1'b1});
      vecs.push_back('{16'habcd, 4'h4, 1'b0, 2, 7'b0000011, 1'b0});
      vecs.push_back('{16'habcd, 4'h4, 1'b0, 1, 7'b1000110, 1'b1});

      // Power-up reset
      rst = 1'b1; in_r = 16'h1234; dp_r = 4'h0; en_r = 1'b1; lz_r = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", 32'(out), 32'h7f);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_frame", 32'(frame), 32'h0);
      rst = 1'b0;
      model_reset();
      repeat (7) step();

      // Reset asserted mid-scan blanks outputs with no clock edge
      #2 rst = 1'b1;
      #1;
      check("arst_out", 32'(out), 32'h7f);
      check("arst_sel", 32'(sel), 32'h0);
      check("arst_dp", 32'(dp), 32'h1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      step();
      check("su_frame", 32'(frame), 32'h1);
      step();
      check("su_sel", 32'(sel), 32'h1);
      check("su_out", 32'(out), 32'b0011001);

      // Scan order and frame period
      in_r = 16'habcd;
      wait_frame();
      for (int j = 0; j < D; j++) begin
         step();
         check("scan_blank", 32'(sel), 32'h0);
         repeat (S-1) step();
         check("scan_sel", 32'(sel), 32'(1 << j));
         check("scan_out", 32'(out), 32'(scan_exp[j]));
      end
      check("frame_period", 32'(frame), 32'h1);

      // Snapshot integrity: in changes while digit 2 is on
      in_r = 16'h1111;
      wait_frame();
      step();
      wait_sel(4'b0100);
      in_r = 16'h2222;
      step();
      check("snap_d2", 32'(out), 32'b1111001);
      wait_sel(4'b1000);
      check("snap_d3", 32'(out), 32'b1111001);
      wait_frame();
      step();
      wait_sel(4'b0001);
      check("snap_d0_new", 32'(out), 32'b0100100);

      // Vector table
      foreach (vecs[i]) begin
         in_r = vecs[i].v; dp_r = vecs[i].dpi; lz_r = vecs[i].lz;
         wait_frame();
         step();
         wait_sel(4'(1 << vecs[i].dig));
         check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].eo));
         check($sformatf("vec%0d_dp", i), 32'(dp), 32'(vecs[i].ed));
      end

      // Enable off for 5 cycles mid-frame, then resume in phase
      in_r = 16'h1234; dp_r = 4'h0; lz_r = 1'b0;
      repeat (6) step();
      en_r = 1'b0;
      repeat (5) begin
         step();
         check("en_off_sel", 32'(sel), 32'h0);
      end
      en_r = 1'b1;
      repeat (2*FP) step();

      // dp lit only on digit 2
      dp_r = 4'b0100;
      wait_frame();
      repeat (FP) begin
         step();
         check("dp_only", 32'(dp), 32'(sel != 4'b0100));
      end

      // Random stimulus against the model
      repeat (800) begin
         if ($urandom_range(0, 7) == 0) in_r = 16'($urandom);
         if ($urandom_range(0, 15) == 0) in_r = {12'h000, 4'($urandom)};
         if ($urandom_range(0, 11) == 0) dp_r = 4'($urandom);
         if ($urandom_range(0, 23) == 0) lz_r = 1'($urandom);
         en_r = ($urandom_range(0, 9) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Parametrised, time-multiplexed hex display driver for common-segment 7-segment banks of `DIGITS` digits. It snapshots a packed hex value once per scan frame, then cycles digit selects at a programmable refresh rate. Each switch gets a one-cycle anti-ghost blank, and leading-zero suppression and decimal points are supported. It sits between datapath result registers (divider quotient/remainder, counters) and the board's segment/select pins.

## Interface

Parameters:
- `DIGITS`, 4: number of digits driven; ≥1.
- `SCAN_DIV`, 50000: clock cycles each digit slot lasts, including its blank cycle; ≥2.
- `SEG_ACTIVE_LOW`, 1: 1 = segment lit by 0 (board default); 0 = lit by 1.
- `SEL_ACTIVE_HIGH`, 1: 1 = digit selected by 1; 0 = selected by 0.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `in` in 4*DIGITS: packed hex value; digit i = `in[4i+3:4i]`, digit 0 rightmost.
- `dp_in` in DIGITS: decimal point request per digit, 1 = lit.
- `en` in 1: display enable; 0 blanks all outputs, scanning continues.
- `lz_blank` in 1: 1 = suppress leading zeros.
- `out` out 7: segments {g,f,e,d,c,b,a}, polarity per `SEG_ACTIVE_LOW`.
- `dp` out 1: decimal point segment, same polarity as `out`.
- `sel` out DIGITS: one-hot digit select, polarity per `SEL_ACTIVE_HIGH`.
- `frame` out 1: one-cycle pulse when a new snapshot is taken.

## Operation

- Prescaler `pcnt`, width clog2(SCAN_DIV): counts 0..SCAN_DIV-1, then wraps. `tick` = (pcnt == SCAN_DIV-1).
- Digit index `idx`: advances on `tick`. It wraps DIGITS-1 → 0. With DIGITS=1 it stays at 0.
- Snapshot: `shadow <= in` and `dp_sh <= dp_in` on the tick where idx wraps to 0.
  - A `primed` flag (reset 0) also forces a snapshot on the first edge after reset release, then sets to 1.
  - `frame` pulses on every snapshot. `in` changes mid-frame never tear the display.
- Blank flag `bl`: set on the edge `tick` is seen, cleared next edge. It is also set on the first edge after reset.
- Decode, in active-low form, then inverted if `SEG_ACTIVE_LOW`=0:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading zeros: when `lz_blank`=1, digit i>0 is suppressed if it and all higher digits are 0 in `shadow`. A suppressed digit drives segments off and `dp` per `dp_sh[i]`. Digit 0 is never suppressed.
- Output register, updated every cycle:
  - If `rst`, `en`=0 or `bl`=1: sel all inactive, segments off, dp off.
  - Otherwise: sel bit `idx` active (others inactive), `out` = decode(shadow digit idx) or off if suppressed, `dp` = `dp_sh[idx]`.
- `en` and `lz_blank` are sampled combinationally into the output register, so they take effect one cycle later.

## Timing

- Reset values:
  - `pcnt`=0, `idx`=0, `shadow`=0, `dp_sh`=0, `primed`=0, `bl`=1.
  - `out` = all off (7'b1111111 when SEG_ACTIVE_LOW=1).
  - `dp` off; `sel` all inactive (0 when SEL_ACTIVE_HIGH=1); `frame`=0.
- First edge after reset release: snapshot taken, `frame`=1 for that cycle, `bl` clears.
- Second edge: outputs show digit 0.
- Slot timing, with the tick seen at edge T (idx changes at T):
  - T+1: outputs blank.
  - T+2: new digit shown.
  - Each slot = SCAN_DIV cycles: 1 blank plus SCAN_DIV-1 lit.
- Frame period = DIGITS*SCAN_DIV cycles. `frame` is high in the cycle following the wrap edge.
- Reset asserted mid-scan: all registers return to reset values immediately (asynchronous), and outputs go blank without waiting for a clock.
- `en` toggling does not disturb `pcnt`, `idx` or the snapshot. Display resumes in phase.
- Latency from an `in` change to display: at most DIGITS*SCAN_DIV+2 cycles.

## Test plan

All scenarios use DIGITS=4, SCAN_DIV=4 and default polarities.

- Reset and start-up:
  - Stimulus: assert `rst` mid-frame, `in`=16'h1234.
  - Required: outputs go to out=1111111, sel=0000 with no clock edge.
  - After release: frame=1 on edge 1; on edge 2, sel=0001, out=0011001 (4).
- Scan order:
  - Stimulus: `in`=16'hABCD, `en`=1.
  - Required: per slot, one blank cycle, then 3 cycles of sel=0001/d, 0010/C, 0100/b, 1000/A. Frame period is 16 cycles.
- Snapshot integrity:
  - Stimulus: change `in` from 16'h1111 to 16'h2222 while idx=2.
  - Required: digits 2 and 3 still show 1. Digit 0 shows 2 only after the next `frame` pulse.
- Leading zeros:
  - Stimulus: `in`=16'h0050, `lz_blank`=1.
  - Required: digits 3 and 2 are selected with out=1111111. Digit 1 shows 5, and digit 0 shows 0 (1000000).
  - With `in`=0, only digit 0 is lit, showing 0.
- Enable and dp:
  - Stimulus: `en`=0 for 5 cycles mid-frame.
  - Required: sel=0000; `idx` keeps advancing, so re-enable resumes at the correct digit.
  - With `dp_in`=4'b0100: dp=0 only while sel=0100.
